// File: rtl/fu_complete_arbiter_pkg.sv
// Shared definitions for the functional-unit completion arbiter:
// completion packet layout, default sizing and FU index map.
package fu_complete_arbiter_pkg;

  localparam int DEFAULT_NUM_FU = 4;
  localparam int DEFAULT_CDB_W  = 2;

  localparam int FU_IDX_ALU0 = 0;
  localparam int FU_IDX_ALU1 = 1;
  localparam int FU_IDX_MULT = 2;
  localparam int FU_IDX_BR   = 3;

  // Result produced by a functional unit; the arbiter never looks inside it.
  typedef struct packed {
    logic [31:0] dest_value;
    logic [5:0]  dest_prn;
    logic [4:0]  rob_idx;
    logic        take_branch;
    logic [31:0] branch_target;
  } FU_COMPLETE_PACKET;

endpackage

// File: rtl/fu_complete_arbiter_if.sv
// Completion request / CDB broadcast bundle between the FUs and the arbiter.
interface fu_complete_arbiter_if
  import fu_complete_arbiter_pkg::*;
#(
  parameter int NUM_FU = DEFAULT_NUM_FU,
  parameter int CDB_W  = DEFAULT_CDB_W
);
  localparam int IDX_W = $clog2(NUM_FU);

  logic [NUM_FU-1:0]                fu_complete_req;
  FU_COMPLETE_PACKET [NUM_FU-1:0]   fu_pkt;
  logic [NUM_FU-1:0]                fu_hazard;
  logic [CDB_W-1:0]                 cdb_valid;
  FU_COMPLETE_PACKET [CDB_W-1:0]    cdb_pkt;
  logic [CDB_W-1:0][IDX_W-1:0]      cdb_src;

  // FU side: raises requests and packets, watches stalls and the CDB
  modport master (
    output fu_complete_req, fu_pkt,
    input  fu_hazard, cdb_valid, cdb_pkt, cdb_src
  );

  // Arbiter side
  modport slave (
    input  fu_complete_req, fu_pkt,
    output fu_hazard, cdb_valid, cdb_pkt, cdb_src
  );

endinterface

// File: rtl/fu_complete_arbiter_rr_multi_grant.sv
// Combinational round-robin picker that hands out up to CDB_W grants per
// cycle, starting the scan at the priority pointer and wrapping around.
module fu_complete_arbiter_rr_multi_grant
  import fu_complete_arbiter_pkg::*;
#(
  parameter int NUM_FU = DEFAULT_NUM_FU,
  parameter int CDB_W  = DEFAULT_CDB_W
) (
  input  logic [NUM_FU-1:0]                    req,
  input  logic [$clog2(NUM_FU)-1:0]            ptr,
  output logic [CDB_W-1:0][NUM_FU-1:0]         grant_oh,
  output logic [CDB_W-1:0]                     port_valid,
  output logic [CDB_W-1:0][$clog2(NUM_FU)-1:0] port_idx,
  output logic [NUM_FU-1:0]                    grant,
  output logic [$clog2(NUM_FU)-1:0]            next_ptr
);
  localparam int IDX_W = $clog2(NUM_FU);

  // Walk ptr, ptr+1, ... and give the k-th requester found to port k
  always_comb begin
    int cnt;
    int idx;
    grant_oh   = '0;
    port_valid = '0;
    port_idx   = '0;
    grant      = '0;
    next_ptr   = ptr;
    cnt        = 0;
    idx        = 0;
    for (int s = 0; s < NUM_FU; s++) begin
      idx = (int'(ptr) + s) % NUM_FU;
      if (req[idx] && (cnt < CDB_W)) begin
        grant_oh[cnt][idx] = 1'b1;
        port_valid[cnt]    = 1'b1;
        port_idx[cnt]      = IDX_W'(idx);
        grant[idx]         = 1'b1;
        next_ptr           = IDX_W'((idx + 1) % NUM_FU);
        cnt                = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/fu_complete_arbiter.sv
// Shares the CDB write-back ports among completing functional units.
// Holds the round-robin pointer and registered CDB outputs, and tells each
// ungranted FU to hold its result through fu_hazard.
module fu_complete_arbiter
  import fu_complete_arbiter_pkg::*;
#(
  parameter int NUM_FU = DEFAULT_NUM_FU,
  parameter int CDB_W  = DEFAULT_CDB_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 squash,
  fu_complete_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_FU);

  logic [IDX_W-1:0]            rr_ptr;
  logic [IDX_W-1:0]            next_ptr;
  logic [NUM_FU-1:0]           eff_req;
  logic [NUM_FU-1:0]           grant;
  logic [CDB_W-1:0][NUM_FU-1:0] grant_oh;
  logic [CDB_W-1:0]            port_valid;
  logic [CDB_W-1:0][IDX_W-1:0] port_idx;
  FU_COMPLETE_PACKET [CDB_W-1:0] sel_pkt;

  // Reset and squash suppress all requests, so nothing is granted and no
  // FU is told to stall while either is active.
  assign eff_req       = (rst && !squash) ? bus.fu_complete_req : '0;
  assign bus.fu_hazard = eff_req & ~grant;

  fu_complete_arbiter_rr_multi_grant #(
    .NUM_FU (NUM_FU),
    .CDB_W  (CDB_W)
  ) u_rr (
    .req        (eff_req),
    .ptr        (rr_ptr),
    .grant_oh   (grant_oh),
    .port_valid (port_valid),
    .port_idx   (port_idx),
    .grant      (grant),
    .next_ptr   (next_ptr)
  );

  // One-hot AND-OR mux from each port's granted FU onto its packet
  always_comb begin
    sel_pkt = '0;
    for (int k = 0; k < CDB_W; k++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (grant_oh[k][i]) begin
          sel_pkt[k] = sel_pkt[k] | bus.fu_pkt[i];
        end
      end
    end
  end

  // Priority pointer: restart at 0 on squash, else move past the last grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (squash) begin
      rr_ptr <= '0;
    end else if (|grant) begin
      rr_ptr <= next_ptr;
    end
  end

  // CDB output registers; unused ports drop valid but keep stale payload
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.cdb_valid <= '0;
      bus.cdb_pkt   <= '0;
      bus.cdb_src   <= '0;
    end else begin
      for (int k = 0; k < CDB_W; k++) begin
        if (port_valid[k]) begin
          bus.cdb_valid[k] <= 1'b1;
          bus.cdb_pkt[k]   <= sel_pkt[k];
          bus.cdb_src[k]   <= port_idx[k];
        end else begin
          bus.cdb_valid[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fu_complete_arbiter.sv
// Bench for the FU completion arbiter: directed scenarios plus a random
// run compared against a scan-order reference model.
module tb_fu_complete_arbiter;
  import fu_complete_arbiter_pkg::*;

  localparam int NUM_FU = 4;
  localparam int CDB_W  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic squash = 1'b0;

  int checks = 0;
  int failures = 0;

  int m_ptr = 0;
  int exp_q[$];
  FU_COMPLETE_PACKET snap_pkt [NUM_FU];

  fu_complete_arbiter_if #(.NUM_FU(NUM_FU), .CDB_W(CDB_W)) bus ();

  fu_complete_arbiter #(.NUM_FU(NUM_FU), .CDB_W(CDB_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .squash (squash),
    .bus    (bus)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Bound on total run time
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, got running, need finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic FU_COMPLETE_PACKET rand_pkt();
    FU_COMPLETE_PACKET p;
    p.dest_value    = $urandom;
    p.dest_prn      = 6'($urandom);
    p.rob_idx       = 5'($urandom);
    p.take_branch   = 1'($urandom);
    p.branch_target = $urandom;
    return p;
  endfunction

  // Reference: list the first CDB_W requesters in priority order from m_ptr
  function automatic void model_pick(input logic [NUM_FU-1:0] req, input logic sq);
    exp_q.delete();
    if (sq) return;
    for (int s = 0; s < NUM_FU; s++) begin
      int f;
      f = (m_ptr + s) % NUM_FU;
      if (req[f] && exp_q.size() < CDB_W) exp_q.push_back(f);
    end
  endfunction

  function automatic logic [NUM_FU-1:0] model_hazard(input logic [NUM_FU-1:0] req, input logic sq);
    logic [NUM_FU-1:0] h;
    if (sq) return '0;
    h = req;
    foreach (exp_q[j]) h[exp_q[j]] = 1'b0;
    return h;
  endfunction

  function automatic void model_advance(input logic sq);
    if (sq) m_ptr = 0;
    else if (exp_q.size() > 0) m_ptr = (exp_q[exp_q.size()-1] + 1) % NUM_FU;
  endfunction

  function automatic logic [CDB_W-1:0] model_valid();
    logic [CDB_W-1:0] v;
    v = '0;
    for (int k = 0; k < CDB_W; k++) if (k < exp_q.size()) v[k] = 1'b1;
    return v;
  endfunction

  task automatic snapshot();
    for (int i = 0; i < NUM_FU; i++) snap_pkt[i] = bus.fu_pkt[i];
  endtask

  task automatic randomize_pkts();
    for (int i = 0; i < NUM_FU; i++) bus.fu_pkt[i] = rand_pkt();
  endtask

  task automatic test_reset();
    logic [NUM_FU-1:0] eh;
    rst = 1'b0;
    squash = 1'b0;
    bus.fu_complete_req = 4'b1111;
    randomize_pkts();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.cdb_valid !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_valid: got %b need 00", bus.cdb_valid);
    end
    checks++;
    if (bus.fu_hazard !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_hazard: got %b need 0000", bus.fu_hazard);
    end
    checks++;
    if (bus.cdb_src !== '0 || bus.cdb_pkt !== '0) begin
      failures++;
      $display("[TB] FAIL reset_payload: got src %h pkt %h need zero", bus.cdb_src, bus.cdb_pkt);
    end
    // squash arrives together with reset release: first edge applies squash
    @(negedge clk);
    squash = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.fu_hazard !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL release_squash_hazard: got %b need 0000", bus.fu_hazard);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.cdb_valid !== 2'b00) begin
      failures++;
      $display("[TB] FAIL release_squash_valid: got %b need 00", bus.cdb_valid);
    end
    m_ptr = 0;
    @(negedge clk);
    squash = 1'b0;
    model_pick(bus.fu_complete_req, 1'b0);
    eh = model_hazard(bus.fu_complete_req, 1'b0);
    snapshot();
    #1;
    checks++;
    if (bus.fu_hazard !== eh || eh !== 4'b1100) begin
      failures++;
      $display("[TB] FAIL first_grant_hazard: got %b need 1100", bus.fu_hazard);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.cdb_valid !== 2'b11 || bus.cdb_src[0] !== 2'd0 || bus.cdb_src[1] !== 2'd1) begin
      failures++;
      $display("[TB] FAIL first_grant_ports: got valid %b src0 %0d src1 %0d need 11/0/1",
               bus.cdb_valid, bus.cdb_src[0], bus.cdb_src[1]);
    end
    model_advance(1'b0);
  endtask

  task automatic test_single_mult();
    FU_COMPLETE_PACKET p;
    @(negedge clk);
    bus.fu_complete_req = 4'b0100;
    randomize_pkts();
    p = bus.fu_pkt[FU_IDX_MULT];
    p.dest_value = 32'h23;
    bus.fu_pkt[FU_IDX_MULT] = p;
    model_pick(bus.fu_complete_req, 1'b0);
    #1;
    checks++;
    if (bus.fu_hazard !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL mult_hazard: got %b need 0000", bus.fu_hazard);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.cdb_valid !== 2'b01 || bus.cdb_pkt[0].dest_value !== 32'h23 || bus.cdb_src[0] !== 2'd2) begin
      failures++;
      $display("[TB] FAIL mult_broadcast: got valid %b value %h src %0d need 01/23/2",
               bus.cdb_valid, bus.cdb_pkt[0].dest_value, bus.cdb_src[0]);
    end
    checks++;
    if (bus.cdb_pkt[0] !== p) begin
      failures++;
      $display("[TB] FAIL mult_packet: got %h need %h", bus.cdb_pkt[0], p);
    end
    model_advance(1'b0);
    @(negedge clk);
    bus.fu_complete_req = 4'b0000;
  endtask

  task automatic test_oversubscription();
    // one squash cycle brings the pointer back to FU0
    @(negedge clk);
    squash = 1'b1;
    @(posedge clk);
    m_ptr = 0;
    @(negedge clk);
    squash = 1'b0;
    bus.fu_complete_req = 4'b1111;
    randomize_pkts();
    snapshot();
    #1;
    checks++;
    if (bus.fu_hazard !== 4'b1100) begin
      failures++;
      $display("[TB] FAIL over_hazard1: got %b need 1100", bus.fu_hazard);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.cdb_valid !== 2'b11 || bus.cdb_src[0] !== 2'd0 || bus.cdb_src[1] !== 2'd1 ||
        bus.cdb_pkt[0] !== snap_pkt[0] || bus.cdb_pkt[1] !== snap_pkt[1]) begin
      failures++;
      $display("[TB] FAIL over_ports1: got valid %b src %0d,%0d need 11 src 0,1 with FU0/FU1 packets",
               bus.cdb_valid, bus.cdb_src[0], bus.cdb_src[1]);
    end
    @(negedge clk);
    bus.fu_complete_req = 4'b1100;
    #1;
    checks++;
    if (bus.fu_hazard !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL over_hazard2: got %b need 0000", bus.fu_hazard);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.cdb_valid !== 2'b11 || bus.cdb_src[0] !== 2'd2 || bus.cdb_src[1] !== 2'd3 ||
        bus.cdb_pkt[0] !== snap_pkt[2] || bus.cdb_pkt[1] !== snap_pkt[3]) begin
      failures++;
      $display("[TB] FAIL over_ports2: got valid %b src %0d,%0d need 11 src 2,3 with held packets",
               bus.cdb_valid, bus.cdb_src[0], bus.cdb_src[1]);
    end
    // pointer has wrapped to FU0
    @(negedge clk);
    bus.fu_complete_req = 4'b1111;
    #1;
    checks++;
    if (bus.fu_hazard !== 4'b1100) begin
      failures++;
      $display("[TB] FAIL over_wrap: got hazard %b need 1100", bus.fu_hazard);
    end
    @(posedge clk);
    m_ptr = 2;
    @(negedge clk);
    bus.fu_complete_req = 4'b0000;
    @(posedge clk);
    #1;
    checks++;
    if (bus.cdb_valid !== 2'b00) begin
      failures++;
      $display("[TB] FAIL idle_valid: got %b need 00", bus.cdb_valid);
    end
  endtask

  task automatic test_fairness();
    int grants [NUM_FU];
    int run [NUM_FU];
    int worst [NUM_FU];
    for (int i = 0; i < NUM_FU; i++) begin
      grants[i] = 0;
      run[i] = 0;
      worst[i] = 0;
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.fu_complete_req = 4'b1111;
      #1;
      for (int i = 0; i < NUM_FU; i++) begin
        if (bus.fu_hazard[i]) run[i]++;
        else run[i] = 0;
        if (run[i] > worst[i]) worst[i] = run[i];
      end
      model_pick(bus.fu_complete_req, 1'b0);
      @(posedge clk);
      #1;
      for (int k = 0; k < CDB_W; k++) if (bus.cdb_valid[k]) grants[bus.cdb_src[k]]++;
      model_advance(1'b0);
    end
    for (int i = 0; i < NUM_FU; i++) begin
      checks++;
      if (grants[i] !== 4) begin
        failures++;
        $display("[TB] FAIL fair_count_fu%0d: got %0d grants need 4", i, grants[i]);
      end
      checks++;
      if (worst[i] > 1) begin
        failures++;
        $display("[TB] FAIL fair_stall_fu%0d: got %0d consecutive stalls need at most 1", i, worst[i]);
      end
    end
    @(negedge clk);
    bus.fu_complete_req = 4'b0000;
    @(posedge clk);
  endtask

  task automatic test_squash_mid_stall();
    @(negedge clk);
    squash = 1'b1;
    @(posedge clk);
    m_ptr = 0;
    @(negedge clk);
    squash = 1'b0;
    bus.fu_complete_req = 4'b1111;
    randomize_pkts();
    #1;
    checks++;
    if (bus.fu_hazard[FU_IDX_MULT] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL squash_setup: got mult hazard %b need 1", bus.fu_hazard[FU_IDX_MULT]);
    end
    @(negedge clk);
    squash = 1'b1;
    #1;
    checks++;
    if (bus.fu_hazard !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL squash_hazard: got %b need 0000", bus.fu_hazard);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.cdb_valid !== 2'b00) begin
      failures++;
      $display("[TB] FAIL squash_valid: got %b need 00", bus.cdb_valid);
    end
    m_ptr = 0;
    @(negedge clk);
    squash = 1'b0;
    #1;
    checks++;
    if (bus.fu_hazard !== 4'b1100) begin
      failures++;
      $display("[TB] FAIL squash_ptr: got hazard %b need 1100 (pointer at 0)", bus.fu_hazard);
    end
    @(posedge clk);
    m_ptr = 2;
    @(negedge clk);
    bus.fu_complete_req = 4'b0000;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.fu_complete_req = 4'b1111;
    @(posedge clk);
    #1;
    checks++;
    if (bus.cdb_valid !== 2'b11) begin
      failures++;
      $display("[TB] FAIL areset_setup: got %b need 11", bus.cdb_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.cdb_valid !== 2'b00 || bus.cdb_src !== '0 || bus.cdb_pkt !== '0) begin
      failures++;
      $display("[TB] FAIL areset_outputs: got valid %b src %h need all zero", bus.cdb_valid, bus.cdb_src);
    end
    checks++;
    if (bus.fu_hazard !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL areset_hazard: got %b need 0000", bus.fu_hazard);
    end
    @(negedge clk);
    bus.fu_complete_req = 4'b0000;
    rst = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_random();
    logic [NUM_FU-1:0] req;
    logic [NUM_FU-1:0] eh;
    logic [NUM_FU-1:0] held;
    logic sq;
    int bad;
    held = '0;
    req = '0;
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      sq = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < NUM_FU; i++) begin
        if (!held[i]) begin
          req[i] = ($urandom_range(0, 9) < 6);
          bus.fu_pkt[i] = rand_pkt();
        end
      end
      bus.fu_complete_req = req;
      squash = sq;
      snapshot();
      model_pick(req, sq);
      eh = model_hazard(req, sq);
      #1;
      checks++;
      if (bus.fu_hazard !== eh) begin
        failures++;
        bad++;
        if (bad < 10) $display("[TB] FAIL rand_hazard cycle %0d: got %b need %b", c, bus.fu_hazard, eh);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.cdb_valid !== model_valid()) begin
        failures++;
        bad++;
        if (bad < 10) $display("[TB] FAIL rand_valid cycle %0d: got %b need %b", c, bus.cdb_valid, model_valid());
      end
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (int'(bus.cdb_src[k]) !== exp_q[k] || bus.cdb_pkt[k] !== snap_pkt[exp_q[k]]) begin
          failures++;
          bad++;
          if (bad < 10) $display("[TB] FAIL rand_port%0d cycle %0d: got src %0d need src %0d with its packet",
                                 k, c, bus.cdb_src[k], exp_q[k]);
        end
      end
      model_advance(sq);
      held = eh;
    end
    @(negedge clk);
    squash = 1'b0;
    bus.fu_complete_req = '0;
  endtask

  // Scenario sequence
  initial begin
    bus.fu_complete_req = '0;
    randomize_pkts();
    $display("[TB] start");
    test_reset();
    test_single_mult();
    test_oversubscription();
    test_fairness();
    test_squash_mid_stall();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fu_complete_arbiter.md
# fu_complete_arbiter

Shares the CDB write-back ports among the execute-stage functional units (ALUs, pipelined multiplier, branch unit). Each cycle it selects up to `CDB_W` completing FUs in round-robin order and registers their `FU_COMPLETE_PACKET`s onto the CDB. It drives a per-FU stall (`fu_hazard`) that feeds each FU's `bs_hazard` input, so an ungranted FU holds its result until it is granted.

## Interface
- `NUM_FU`, 4, number of FU completion requesters (index 0..NUM_FU-1; default map 0=ALU0, 1=ALU1, 2=MULT, 3=BRANCH)
- `CDB_W`, 2, number of CDB broadcast ports; `CDB_W <= NUM_FU`
- `clk  in  1  clock`
- `rst  in  1  asynchronous, active-low reset (low = reset)`
- `squash  in  1  synchronous pipeline flush (branch mispredict)`
- `fu_complete_req  in  NUM_FU  per-FU completion request (e.g. fum_complete_req)`
- `fu_pkt  in  NUM_FU x FU_COMPLETE_PACKET  per-FU result packet; valid only while its request is high`
- `fu_hazard  out  NUM_FU  per-FU stall; 1 = not granted this cycle, hold packet`
- `cdb_valid  out  CDB_W  broadcast-port valid, registered`
- `cdb_pkt  out  CDB_W x FU_COMPLETE_PACKET  broadcast packet, registered`
- `cdb_src  out  CDB_W x $clog2(NUM_FU)  granted FU index per port, registered`

## Operation
- State:
  - `rr_ptr` (`$clog2(NUM_FU)` bits): the highest-priority FU index.
  - Output registers `cdb_valid`, `cdb_pkt`, `cdb_src`.
- Grant (combinational):
  - Scan indices `rr_ptr, rr_ptr+1, … mod NUM_FU`.
  - The first `CDB_W` FUs with `fu_complete_req=1` are granted.
  - The k-th grant in scan order goes to port k. Ports beyond the number of grants are invalid.
- Hazard (combinational, same cycle as request):
  - `fu_hazard[i] = fu_complete_req[i] & ~grant[i]`.
  - Non-requesting FUs see 0.
- Pointer update at posedge:
  - If at least one grant: `rr_ptr <= (index of last granted FU + 1) mod NUM_FU`.
  - Otherwise unchanged.
- Output capture at posedge:
  - Port k gets `cdb_valid[k] <= 1`, plus the granted FU's packet and index.
  - Unused ports get `cdb_valid[k] <= 0`. `cdb_pkt`/`cdb_src` on unused ports hold their value (don't-care).
- Squash (synchronous):
  - While `squash=1`: no grants, `fu_hazard` all 0.
  - At posedge: `cdb_valid <= 0`, `rr_ptr <= 0`.
  - Squash takes priority over any request.
- Reset (`rst=0`, asynchronous, any time including mid-stall):
  - `cdb_valid=0`, `cdb_pkt=0`, `cdb_src=0`, `rr_ptr=0` immediately.
  - `fu_hazard` forced to 0 while in reset.
- The arbiter does not inspect packet contents. Granting is purely request-based.

## Timing
- Latency: request at cycle N with grant means the packet appears on `cdb_pkt` after the posedge ending cycle N (visible in cycle N+1).
- `fu_hazard` is valid in the same cycle as the request. FUs sample it at the same posedge to decide whether to hold.
- A stalled FU keeps its request and packet stable until granted. The arbiter re-evaluates every cycle and needs no memory of stalled FUs.
- Starvation bound: any continuously requesting FU is granted within `ceil(NUM_FU / CDB_W)` cycles (2 cycles for the defaults).
- Boundary cases:
  - No requests: all `cdb_valid` 0 next cycle, pointer held.
  - Requests ≤ `CDB_W`: all granted, no hazard.
  - Pointer wrap: NUM_FU-1 → 0.
  - `squash` together with a reset release: reset dominates; the first active edge after release applies squash.

## Structure
- Shared package (`sys_defs.svh`):
  - `FU_COMPLETE_PACKET` (already present).
  - Default `NUM_FU`/`CDB_W` constants.
  - FU index constants (`FU_IDX_ALU0`, `FU_IDX_ALU1`, `FU_IDX_MULT`, `FU_IDX_BR`).
- Natural sub-module: `rr_multi_grant`
  - Purely combinational.
  - Inputs: request vector, pointer.
  - Outputs: `CDB_W` one-hot grants in scan order, plus the next pointer.
- The top holds the pointer, output registers, squash and hazard logic.

## Test plan
Defaults NUM_FU=4, CDB_W=2.
- **Reset:** hold `rst=0` with all requests high → `cdb_valid=00`, `fu_hazard=0000`, `cdb_src=0`. Release; first grant uses `rr_ptr=0`.
- **Single multiplier completion:** `req=0100`, `fu_pkt[2].dest_value=32'h23` → `fu_hazard=0000`. Next cycle `cdb_valid=01`, `cdb_pkt[0].dest_value=32'h23`, `cdb_src[0]=2`.
- **Oversubscription:** `req=1111` with `rr_ptr=0` → `fu_hazard=1100`. Next cycle ports carry FU0 and FU1; FU2/FU3 hold. Second cycle `fu_hazard=0000`, ports carry FU2 and FU3, `rr_ptr` wraps to 0.
- **Fairness:** `req=1111` held for 8 cycles → each FU granted exactly 4 times, no FU stalled more than 1 consecutive cycle.
- **Squash mid-stall:** MULT stalled (`fu_hazard[2]=1`), then `squash=1` → `fu_hazard=0000` that cycle. Next cycle `cdb_valid=00`, `rr_ptr=0`.
- **Asynchronous reset mid-broadcast:** `cdb_valid=11`, drive `rst=0` between clock edges → `cdb_valid=00` before the next posedge.
